ll_rd_arbiter: RTL
==================

# ll_rd_arbiter

Read-port arbiter and sequencer for the link-list next-pointer SRAM. It shares the single SRAM read port between four packet-read channels and the drop channel. Requests are accepted with a valid/ready handshake. Each granted read is routed back to its requester one cycle later. The drop channel has strict priority, bounded by an anti-starvation limit.

## Interface
- ADDR_LENTH, 12, width of a link-list address/data word
- DROP_BURST_MAX, 4, maximum consecutive drop grants while any read channel is pending (1..15)

- iClk  in  1  clock, all logic rising-edge
- iRst  in  1  reset, asynchronous, active-high
- iReqVld  in  4  per-channel read request valid (bit n = channel n)
- iReqAddr  in  4*ADDR_LENTH  per-channel read address; channel n at [n*ADDR_LENTH +: ADDR_LENTH]
- oReqRdy  out  4  one-hot grant; request n accepted when iReqVld[n] & oReqRdy[n]
- oRspData  out  ADDR_LENTH  read data, shared by all channels
- oRspVld  out  4  one-hot response valid, qualifies oRspData for channel n
- iDropVld  in  1  drop-channel read request valid
- iDropAddr  in  ADDR_LENTH  drop-channel read address
- oDropRdy  out  1  drop request accepted
- oDropData  out  ADDR_LENTH  drop-channel read data
- oDropDataVld  out  1  drop-channel response valid
- oRamRen  out  1  SRAM read enable
- oRamRaddr  out  ADDR_LENTH  SRAM read address
- iRamRdata  in  ADDR_LENTH  SRAM read data, valid the cycle after oRamRen

## Operation
- Grant logic is combinational from the current requests and registered state. At most one grant per cycle across oReqRdy and oDropRdy.
- Priority:
  - Drop has priority when iDropVld=1 and the drop burst counter is below DROP_BURST_MAX. Also has priority when no read channel is valid.
  - Otherwise, round-robin among the valid read channels, starting at pointer rRrPtr (0..3) and searching upward with wrap 3->0.
- Drop burst counter (4-bit):
  - Increments on a drop grant while any iReqVld bit is set.
  - Clears on any read-channel grant, or in any cycle with iReqVld==0.
  - Saturates at DROP_BURST_MAX.
  - While saturated with read requests pending, drop is held off for one read grant.
- Round-robin pointer: after a grant to channel n, rRrPtr <= (n+1) mod 4. Drop grants leave it unchanged.
- SRAM drive:
  - oRamRen = any grant.
  - oRamRaddr = address of the granted requester; 0 when no grant.
- Response tag: a registered tag {vld, drop, chan[1:0]} captures the grant in the cycle it is issued.
- Response routing in the next cycle:
  - Read-channel tag: oRspVld[chan]=1 and oRspData=iRamRdata.
  - Drop tag: oDropDataVld=1 and oDropData=iRamRdata.
  - Non-selected outputs are 0 (data and valid).
- A channel may re-request in its own response cycle. Back-to-back grants to one channel are legal when it is the only requester.
- Requesters must hold iReqVld/iReqAddr stable until accepted. Address changes before acceptance are ignored. The sampled address is the one present in the grant cycle.

## Timing
- Request-to-grant: 0 cycles (same cycle) when no higher-priority or earlier round-robin requester competes.
- Grant-to-response: exactly 1 cycle. Throughput: one read per cycle, sustained.
- Reset values: oReqRdy=0, oDropRdy=0, oRamRen=0, oRamRaddr=0, oRspVld=0, oRspData=0, oDropDataVld=0, oDropData=0, rRrPtr=0, burst counter=0, tag vld=0.
- Outputs are forced 0 while iRst=1, regardless of request inputs.
- Reset asserted mid-operation: an in-flight tag is cleared. The response of the read granted in the cycle before reset is never presented. The requester must re-issue.
- Simultaneous drop and read at the DROP_BURST_MAX boundary: the read channel wins that cycle, the counter clears, and drop wins the next cycle.
- No requests: oRamRen=0 and the tag is invalid next cycle. The pointer and counter hold (counter clears, per rule above).

## Test plan
- Reset then single channel: iReqVld=4'b0100, addr 0x123 -> oReqRdy=4'b0100 and oRamRaddr=0x123 same cycle. Model RAM returns 0xABC -> next cycle oRspVld=4'b0100, oRspData=0xABC.
- All four channels valid continuously from reset -> grant order 0,1,2,3,0,... one per cycle. Each response lands on the matching oRspVld bit one cycle after its grant.
- Drop priority: iDropVld and iReqVld=4'b1111 held with DROP_BURST_MAX=4 -> grants D,D,D,D,ch0,D,D,D,D,ch1... Drop data appears only on oDropData/oDropDataVld.
- Drop alone held 10 cycles with no read requests -> 10 consecutive drop grants. The burst counter never saturates and the pointer stays 0.
- Channel 2 only, held 3 cycles -> three back-to-back grants. oRspVld[2] high for three consecutive cycles with distinct data. rRrPtr ends at 3.
- Assert iRst for one cycle immediately after a grant to channel 1 -> no oRspVld pulse. All outputs 0 during reset. After release, first grant follows round-robin from pointer 0.

Source files
------------

// File: rtl/ll_rd_arbiter.sv
// ll_rd_arbiter: shares the link-list next-pointer SRAM read port between
// four packet-read channels and the drop channel. Drop has strict priority,
// bounded by a burst limit; read channels are served round-robin. Each
// granted read is returned to its requester exactly one cycle later.
module ll_rd_arbiter #(
    parameter int ADDR_LENTH     = 12,
    parameter int DROP_BURST_MAX = 4
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [3:0]              iReqVld,
    input  logic [4*ADDR_LENTH-1:0] iReqAddr,
    output logic [3:0]              oReqRdy,
    output logic [ADDR_LENTH-1:0]   oRspData,
    output logic [3:0]              oRspVld,
    input  logic                    iDropVld,
    input  logic [ADDR_LENTH-1:0]   iDropAddr,
    output logic                    oDropRdy,
    output logic [ADDR_LENTH-1:0]   oDropData,
    output logic                    oDropDataVld,
    output logic                    oRamRen,
    output logic [ADDR_LENTH-1:0]   oRamRaddr,
    input  logic [ADDR_LENTH-1:0]   iRamRdata
);

    localparam logic [3:0] BURST_MAX = 4'(DROP_BURST_MAX);

    // Registered state
    logic [1:0] rr_ptr_q,    rr_ptr_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       tag_vld_q,   tag_vld_d;
    logic       tag_drop_q,  tag_drop_d;
    logic [1:0] tag_chan_q,  tag_chan_d;

    // Grant decode
    logic                  rd_any;
    logic                  drop_gnt;
    logic                  rd_gnt;
    logic [1:0]            rd_chan;
    logic [1:0]            idx;
    logic                  found;
    logic [ADDR_LENTH-1:0] rd_addr;

    // Pick at most one winner: drop first unless its burst is exhausted while
    // reads wait, otherwise the first valid channel at or above the pointer.
    // Reset forces every grant low so nothing reaches the SRAM.
    always_comb begin
        rd_any   = |iReqVld;
        drop_gnt = 1'b0;
        rd_gnt   = 1'b0;
        rd_chan  = 2'd0;
        idx      = 2'd0;
        found    = 1'b0;
        if (!iRst) begin
            if (iDropVld && ((burst_cnt_q < BURST_MAX) || !rd_any)) begin
                drop_gnt = 1'b1;
            end else if (rd_any) begin
                for (int i = 0; i < 4; i++) begin
                    idx = rr_ptr_q + 2'(i);
                    if (!found && iReqVld[idx]) begin
                        found   = 1'b1;
                        rd_chan = idx;
                    end
                end
                rd_gnt = 1'b1;
            end
        end
    end

    // Select the granted read channel's address slice.
    always_comb begin
        rd_addr = '0;
        for (int n = 0; n < 4; n++) begin
            if (rd_chan == 2'(n)) rd_addr = iReqAddr[n*ADDR_LENTH +: ADDR_LENTH];
        end
    end

    // Next-state: pointer advances past a read winner; the burst counter
    // counts drop grants only while reads are waiting and saturates at the
    // limit, which hands exactly one grant to a read before drop resumes.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (rd_gnt) rr_ptr_d = rd_chan + 2'd1;
        if (!rd_any || rd_gnt) begin
            burst_cnt_d = 4'd0;
        end else if (drop_gnt && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
        tag_vld_d  = rd_gnt | drop_gnt;
        tag_drop_d = drop_gnt;
        tag_chan_d = rd_chan;
    end

    // State registers; reset also kills any in-flight response tag.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rr_ptr_q    <= 2'd0;
            burst_cnt_q <= 4'd0;
            tag_vld_q   <= 1'b0;
            tag_drop_q  <= 1'b0;
            tag_chan_q  <= 2'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_drop_q  <= tag_drop_d;
            tag_chan_q  <= tag_chan_d;
        end
    end

    // SRAM drive and handshake outputs.
    always_comb begin
        oReqRdy   = rd_gnt ? (4'b0001 << rd_chan) : 4'b0000;
        oDropRdy  = drop_gnt;
        oRamRen   = rd_gnt | drop_gnt;
        oRamRaddr = drop_gnt ? iDropAddr : (rd_gnt ? rd_addr : '0);
    end

    // Route last cycle's read data to the requester named by the tag.
    always_comb begin
        oRspVld      = 4'b0000;
        oRspData     = '0;
        oDropDataVld = 1'b0;
        oDropData    = '0;
        if (tag_vld_q && !iRst) begin
            if (tag_drop_q) begin
                oDropDataVld = 1'b1;
                oDropData    = iRamRdata;
            end else begin
                oRspVld  = 4'b0001 << tag_chan_q;
                oRspData = iRamRdata;
            end
        end
    end

endmodule
